fetch_ctrl: RTL

Instruction-fetch sequencer for the 1024-word synchronous instruction ROM (one-cycle read latency, word-indexed address). Owns the fetch PC, issues ROM reads, and absorbs the ROM's latency in a 2-entry skid buffer. Delivers {pc, instr} pairs to decode over a valid/ready handshake. Accepts branch/jump redirects from execute, discarding wrong-path fetches.

---
 rtl/fetch_ctrl.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
//
// Instruction-fetch sequencer for a synchronous instruction ROM with a
// one-cycle read latency and word-indexed addressing. The block owns the fetch
// PC and issues one ROM read per issue cycle. A 2-entry skid buffer absorbs the
// ROM latency, so decode can stall without losing or repeating an instruction.
// {pc, instr} pairs go to decode over a valid/ready handshake. Redirects from
// execute reload the PC and discard all wrong-path fetches.
//
// Handshake: a transfer happens on a rising clk edge when out_valid and
// out_ready are both high. out_valid does not depend on out_ready. While
// out_valid=1 and out_ready=0, out_pc and out_instr hold steady.
//
// Parameters:
//   RESET_PC  fetch PC loaded on reset. Bits [1:0] must be 0.
//   ADDR_W    ROM word-address width. rom_addr = fpc[ADDR_W+1:2].
//
// Ports:
//   clk             rising-edge clock
//   rst             asynchronous, active-high reset
//   rom_addr        ROM word address, driven combinationally from the fetch PC
//   rom_instr       ROM data for the address presented in the previous cycle
//   redirect_valid  one-cycle pulse that loads redirect_pc as the new fetch PC
//   redirect_pc     redirect target. Bits [1:0] are ignored.
//   out_valid       buffer head holds a correct-path instruction
//   out_ready       decode accepts the head entry this cycle
//   out_pc          PC of the head instruction
//   out_instr       head instruction word
//   o_dbg_state     FSM state (0 = RUN, 1 = FLUSH)
//
// Optional feature, enabled by defining the FETCH_PERF_EN macro:
//   perf_fetched    count of instructions accepted by decode (wraps at 2^32)
//   perf_stall      count of cycles with out_valid=1 and out_ready=0
// -----------------------------------------------------------------------------
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 10
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_instr,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_instr,
`ifdef FETCH_PERF_EN
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_stall,
`endif
    output logic              o_dbg_state
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_fpc;
    logic        r_inflight;
    logic [31:0] r_inflight_pc;
    logic [1:0]  r_count;
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [31:0] r_buf_pc    [2];
    logic [31:0] r_buf_instr [2];

    logic        w_pop;
    logic        w_issue;
    logic        w_flush;
    logic        w_capture;
    logic [2:0]  w_occ;

    assign rom_addr    = r_fpc[ADDR_W+1:2];
    assign out_valid   = (r_state == ST_RUN) && (r_count != 2'd0);
    assign out_pc      = r_buf_pc[r_rd_ptr];
    assign out_instr   = r_buf_instr[r_rd_ptr];
    assign o_dbg_state = r_state;

    assign w_pop = out_valid & out_ready;

    // Occupancy after this cycle if nothing new were issued. The entry being
    // popped frees its slot right away. The in-flight read still needs a slot.
    // pop implies count > 0, so the subtraction cannot underflow.
    assign w_occ = {1'b0, r_count} - {2'b00, w_pop} + {2'b00, r_inflight};

    // The data returning in a redirect cycle is wrong-path, so it is dropped.
    assign w_capture = r_inflight & ~redirect_valid;

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_flush     = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (redirect_valid) begin
                    w_flush     = 1'b1;
                    w_state_nxt = ST_FLUSH;
                end else if (w_occ < 3'd2) begin
                    w_issue = 1'b1;
                end
            end
            ST_FLUSH: begin
                // The buffer is empty and nothing is in flight, so the target
                // can always issue.
                if (redirect_valid) begin
                    w_flush = 1'b1;
                end else begin
                    w_issue     = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fpc         <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= 32'd0;
            r_count       <= 2'd0;
            r_rd_ptr      <= 1'b0;
            r_wr_ptr      <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_buf_pc[i]    <= 32'd0;
                r_buf_instr[i] <= 32'd0;
            end
        end else if (w_flush) begin
            r_fpc      <= redirect_pc & 32'hFFFF_FFFC;
            r_inflight <= 1'b0;
            r_count    <= 2'd0;
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
        end else begin
            if (w_issue) begin
                r_inflight    <= 1'b1;
                r_inflight_pc <= r_fpc;
                r_fpc         <= r_fpc + 32'd4;
            end else begin
                r_inflight <= 1'b0;
            end
            if (w_capture) begin
                r_buf_pc[r_wr_ptr]    <= r_inflight_pc;
                r_buf_instr[r_wr_ptr] <= rom_instr;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_capture} - {1'b0, w_pop};
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched <= 32'd0;
            perf_stall   <= 32'd0;
        end else begin
            if (w_pop) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (out_valid && !out_ready) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

    // Issue is throttled on occupancy, so a capture always finds a free slot.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(w_capture && (r_count == 2'd2)));

endmodule
